// File: rtl/line_buffer_scheduler_if.sv
// Handshake bundle between the line writer/reader and the ping-pong scheduler.
// The scheduler takes the slave side; the writer/reader logic takes the master side.
interface line_buffer_scheduler_if #(
  parameter int LINE_W = 11
);
  logic              i_wr_line_done;
  logic              i_rd_line_start;
  logic              i_rd_line_done;
  logic              i_frame_sync;
  logic              o_wr_ready;
  logic              o_wr_sel;
  logic              o_rd_valid;
  logic              o_rd_sel;
  logic [LINE_W-1:0] o_wr_line;
  logic [LINE_W-1:0] o_rd_line;
  logic              o_frame_done;
  logic              o_overflow;
  logic              o_underrun;
  logic [7:0]        o_drop_count;

  modport master (
    output i_wr_line_done, i_rd_line_start, i_rd_line_done, i_frame_sync,
    input  o_wr_ready, o_wr_sel, o_rd_valid, o_rd_sel, o_wr_line, o_rd_line,
           o_frame_done, o_overflow, o_underrun, o_drop_count
  );

  modport slave (
    input  i_wr_line_done, i_rd_line_start, i_rd_line_done, i_frame_sync,
    output o_wr_ready, o_wr_sel, o_rd_valid, o_rd_sel, o_wr_line, o_rd_line,
           o_frame_done, o_overflow, o_underrun, o_drop_count
  );
endinterface

// File: rtl/line_buffer_scheduler.sv
// Ping-pong scheduler for two line buffers shared by one writer and one reader.
// Per-buffer state table:
//   state    | meaning
//   EMPTY    | free, not yet handed to the writer
//   FILLING  | owned by the writer
//   FULL     | complete line waiting for the reader
//   DRAINING | claimed by the reader
module line_buffer_scheduler #(
  parameter int LINES  = 1024,
  parameter int LINE_W = 11
) (
  input logic                     i_clk,
  input logic                     i_rst,
  line_buffer_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    FILLING  = 2'b01,
    FULL     = 2'b10,
    DRAINING = 2'b11
  } buf_state_e;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  buf_state_e        buf_q [2];
  buf_state_e        buf_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        drop_q, drop_d;

  logic              draining;
  logic              drain_idx;
  logic              any_full;
  logic              freed;
  logic              other_sel;

  always_comb begin
    buf_d[0]     = buf_q[0];
    buf_d[1]     = buf_q[1];
    wr_sel_d     = wr_sel_q;
    wr_ready_d   = wr_ready_q;
    rd_ptr_d     = rd_ptr_q;
    wr_line_d    = wr_line_q;
    rd_line_d    = rd_line_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    underrun_d   = underrun_q;
    drop_d       = drop_q;
    rd_valid_d   = 1'b0;

    draining  = (buf_q[0] == DRAINING) || (buf_q[1] == DRAINING);
    drain_idx = (buf_q[1] == DRAINING);
    any_full  = (buf_q[0] == FULL) || (buf_q[1] == FULL);
    freed     = bus.i_rd_line_done && draining;
    other_sel = ~wr_sel_q;

    if (bus.i_frame_sync) begin
      // Flush the frame but keep the sticky error history.
      buf_d[0]   = FILLING;
      buf_d[1]   = EMPTY;
      wr_sel_d   = 1'b0;
      wr_ready_d = 1'b1;
      rd_ptr_d   = 1'b0;
      wr_line_d  = '0;
      rd_line_d  = '0;
    end else begin
      if (bus.i_rd_line_start && !draining) begin
        if (rd_valid_q) begin
          buf_d[rd_ptr_q] = DRAINING;
          rd_ptr_d        = ~rd_ptr_q;
        end else if (!any_full) begin
          underrun_d = 1'b1;
        end
      end

      if (freed) begin
        buf_d[drain_idx] = EMPTY;
        if (rd_line_q == LAST_LINE) begin
          rd_line_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          rd_line_d = rd_line_q + LINE_W'(1);
        end
      end

      if (bus.i_wr_line_done) begin
        if (wr_ready_q) begin
          buf_d[wr_sel_q] = FULL;
          wr_line_d = (wr_line_q == LAST_LINE) ? '0 : wr_line_q + LINE_W'(1);
          if (buf_q[other_sel] == EMPTY || (freed && drain_idx == other_sel)) begin
            buf_d[other_sel] = FILLING;
            wr_sel_d         = other_sel;
          end else begin
            wr_ready_d = 1'b0;
          end
        end else begin
          overflow_d = 1'b1;
          drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
      end

      // A stalled writer gets the buffer the reader just released.
      if (!wr_ready_q && freed) begin
        buf_d[drain_idx] = FILLING;
        wr_ready_d       = 1'b1;
        wr_sel_d         = drain_idx;
      end
    end

    rd_valid_d = ((buf_d[0] == FULL) || (buf_d[1] == FULL)) &&
                 !((buf_d[0] == DRAINING) || (buf_d[1] == DRAINING));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_q[0]     <= FILLING;
      buf_q[1]     <= EMPTY;
      wr_sel_q     <= 1'b0;
      wr_ready_q   <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_line_q    <= '0;
      rd_line_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
      wr_sel_q     <= wr_sel_d;
      wr_ready_q   <= wr_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_line_q    <= wr_line_d;
      rd_line_q    <= rd_line_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.o_wr_ready   = wr_ready_q;
  assign bus.o_wr_sel     = wr_sel_q;
  assign bus.o_rd_valid   = rd_valid_q;
  assign bus.o_rd_sel     = rd_ptr_q;
  assign bus.o_wr_line    = wr_line_q;
  assign bus.o_rd_line    = rd_line_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_underrun   = underrun_q;
  assign bus.o_drop_count = drop_q;

endmodule

// File: doc/line_buffer_scheduler.md
LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 SHALL have parameter LINES, default 1024: lines per frame.
REQ-002 SHALL have parameter LINE_W, default 11: width of line index outputs.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_wr_line_done, input, 1: one-cycle pulse; the writer has finished filling buffer o_wr_sel.
REQ-006 SHALL have port i_rd_line_start, input, 1: one-cycle pulse; the reader claims buffer o_rd_sel.
REQ-007 SHALL have port i_rd_line_done, input, 1: one-cycle pulse; the reader has finished draining the claimed buffer.
REQ-008 SHALL have port i_frame_sync, input, 1: one-cycle pulse; flush and restart the frame.
REQ-009 SHALL have ports o_wr_ready and o_wr_sel, output, 1 each: a buffer is assigned to the writer / index of that buffer.
REQ-010 SHALL have ports o_rd_valid and o_rd_sel, output, 1 each: a full buffer is available / index of that buffer.
REQ-011 SHALL have ports o_wr_line and o_rd_line, output, LINE_W each: line index being written / next line index to read.
REQ-012 SHALL have port o_frame_done, output, 1: one-cycle pulse at end of frame readout.
REQ-013 SHALL have ports o_overflow and o_underrun, output, 1 each: sticky error flags.
REQ-014 SHALL have port o_drop_count, output, 8: count of dropped lines.

Function
REQ-015 SHALL keep one 2-bit state per buffer: EMPTY=00, FILLING=01, FULL=10, DRAINING=11.
REQ-016 SHALL register all outputs; an input sampled on edge N is reflected in the outputs after edge N.
REQ-017 SHALL, on i_wr_line_done with o_wr_ready=1, set buffer o_wr_sel to FULL and increment o_wr_line, wrapping from LINES-1 to 0.
REQ-018 SHALL, on that same edge, set the other buffer to FILLING if it is EMPTY or is being freed that edge, toggle o_wr_sel, and keep o_wr_ready=1; otherwise it SHALL clear o_wr_ready (writer stalled).
REQ-019 SHALL, on i_wr_line_done with o_wr_ready=0, drop the line: o_overflow set, o_drop_count incremented and saturating at 255, no buffer state change, o_wr_line unchanged.
REQ-020 SHALL assert o_rd_valid iff some buffer is FULL and no buffer is DRAINING, with o_rd_sel indicating the oldest FULL buffer; the read pointer toggles on each accepted start.
REQ-021 SHALL, on i_rd_line_start with o_rd_valid=1, set buffer o_rd_sel to DRAINING; o_rd_valid is 0 from the next cycle.
REQ-022 SHALL, on i_rd_line_start with no buffer FULL, set o_underrun and make no state change.
REQ-023 SHALL ignore i_rd_line_start while a buffer is DRAINING, including when i_rd_line_done arrives on the same edge, and SHALL NOT set o_underrun in that case.
REQ-024 SHALL, on i_rd_line_done with a buffer DRAINING, set that buffer to EMPTY and increment o_rd_line, wrapping from LINES-1 to 0.
REQ-025 SHALL pulse o_frame_done for one cycle when o_rd_line wraps from LINES-1 to 0.
REQ-026 SHALL ignore i_rd_line_done when no buffer is DRAINING.
REQ-027 SHALL, while stalled, set the freed buffer to FILLING on an i_rd_line_done edge, with o_wr_ready=1 and o_wr_sel equal to the freed buffer after that edge.
REQ-028 SHALL apply simultaneous i_wr_line_done and i_rd_line_done together; per REQ-018 the freed buffer goes directly to the writer with no stall.
REQ-029 SHALL give i_frame_sync priority over all other inputs on the same edge, producing the reset state of REQ-030 except that o_overflow, o_underrun and o_drop_count are preserved.

Reset
REQ-030 SHALL, on i_rst=1 at a clock edge, set: buffer0 FILLING, buffer1 EMPTY, o_wr_sel=0, o_wr_ready=1, o_rd_valid=0, o_rd_sel=0, read pointer=0, o_wr_line=0, o_rd_line=0, o_frame_done=0, o_overflow=0, o_underrun=0, o_drop_count=0.
REQ-031 SHALL, when reset is asserted mid-line, discard all in-flight buffer states with no completion pulses; i_rst SHALL take priority over i_frame_sync.

Verification
REQ-032 SHALL cover the ping-pong case: after reset, wr_done -> rd_valid=1, rd_sel=0, wr_sel=1; rd_start, rd_done, wr_done -> rd_sel=1, rd_line=1.
REQ-033 SHALL cover stall and drop: two wr_done with no reads -> wr_ready=0; third wr_done -> drop_count=1, overflow=1; rd_start then rd_done -> wr_ready=1, wr_sel=0.
REQ-034 SHALL cover simultaneous events: stalled state with both buffers FULL, buffer0 DRAINING; wr_done and rd_done on the same edge -> wr_done dropped (drop_count+1), buffer0 FILLING, wr_ready=1.
REQ-035 SHALL cover wrap-around with LINES=4: 4 full write/read cycles -> o_frame_done pulses once, rd_line=0, wr_line=0.
REQ-036 SHALL cover underrun and frame sync: rd_start at reset -> underrun=1, state unchanged; frame_sync mid-DRAINING -> reset state with underrun still 1 and drop_count preserved.
